// File: rtl/reduction_nt1.sv
// N-to-1 rule reduction: per-channel dedup, cross-channel merge of identical heads,
// last-marker alignment, round-robin arbitration into a show-ahead output FIFO.

module reduction_nt1_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] win_data,
    input  logic                  load,
    input  logic                  clear,
    output logic                  cached,
    output logic                  req,
    output logic                  match
);
    logic                  cache_valid;
    logic [DATA_WIDTH-1:0] cache_data;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cache_valid <= 1'b0;
            cache_data  <= '0;
        end else if (load) begin
            cache_valid <= 1'b1;
            cache_data  <= data;
        end
    end

    assign cached = valid & ~last & cache_valid & (data == cache_data);
    assign req    = valid & ~last & ~cached;
    assign match  = (data == win_data);
endmodule

module reduction_nt1 #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int FULL_LEVEL = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_last,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  dup_cnt
);
    localparam int PW = $clog2(NUM_IN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = 8;

    logic [NUM_IN-1:0][DATA_WIDTH-1:0] payload;
    logic [NUM_IN-1:0]     cached, req, match, load;
    logic [PW-1:0]         rr_ptr, win;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  all_sync, af, sync_fire, grant;
    logic [IW-1:0]         dup_inc;
    logic [32:0]           dup_sum;

    logic                  stage_valid, stage_last;
    logic [DATA_WIDTH-1:0] stage_data;

    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           occ;
    logic                  pop;

    assign payload = in_data;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        reduction_nt1_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid   (in_valid[g]),
            .last    (in_last[g]),
            .data    (payload[g]),
            .win_data(win_data),
            .load    (load[g]),
            .clear   (sync_fire),
            .cached  (cached[g]),
            .req     (req[g]),
            .match   (match[g])
        );
    end

    // Staged beat counts toward occupancy so it always has a FIFO slot to land in.
    assign occ       = {1'b0, count} + (CW+1)'(stage_valid);
    assign af        = occ >= (CW+1)'(FULL_LEVEL);
    assign all_sync  = (&in_valid) & (&in_last);
    assign sync_fire = !rst && all_sync && !af;
    assign grant     = !rst && !all_sync && !af && (|req);

    // Lowest requester overall, overridden by the lowest at/after the pointer.
    always_comb begin
        win = '0;
        for (int j = NUM_IN-1; j >= 0; j--)
            if (req[j]) win = PW'(j);
        for (int j = NUM_IN-1; j >= 0; j--)
            if (req[j] && PW'(j) >= rr_ptr) win = PW'(j);
    end

    assign win_data = payload[win];

    always_comb begin
        in_ready = '0;
        dup_inc  = '0;
        if (sync_fire) begin
            in_ready = '1;
        end else if (!rst && !all_sync) begin
            in_ready = cached | (match & req & {NUM_IN{grant}});
            for (int j = 0; j < NUM_IN; j++)
                dup_inc = dup_inc + IW'(in_ready[j]);
            if (grant) dup_inc = dup_inc - IW'(1);
        end
    end

    assign load    = in_ready & in_valid & ~in_last;
    assign dup_sum = {1'b0, dup_cnt} + 33'(dup_inc);

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign {out_last, out_data} = out_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            stage_data  <= '0;
            rr_ptr      <= '0;
            dup_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            stage_valid <= sync_fire | grant;
            stage_last  <= sync_fire;
            stage_data  <= sync_fire ? '0 : win_data;
            if (grant)
                rr_ptr <= (win == PW'(NUM_IN-1)) ? '0 : win + PW'(1);
            dup_cnt <= dup_sum[32] ? 32'hFFFF_FFFF : dup_sum[31:0];
            if (stage_valid) wr_ptr <= wr_ptr + AW'(1);
            if (pop)         rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(stage_valid) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && stage_valid)
            fifo_mem[wr_ptr] <= {stage_last, stage_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(stage_valid && count == CW'(FIFO_DEPTH)));
    end
endmodule
